div_op_sequencer: RTL

Front/back-end stage for the Taiga divider: accepts RISC-V DIV/DIVU/REM/REMU operations from issue, converts signed operands to magnitudes, and drives the registered divider core's start/ack handshake. It then applies sign and divide-by-zero fixups to the core's quotient/remainder and presents one result per operation to writeback. A last-operand cache lets a DIV/REM pair on identical operands complete without re-running the core. The block sits between the issue/writeback logic and `div_unit_core_wrapper`, which the parent instantiates beside it.

---
 rtl/taiga_types.sv | 30 +++
 rtl/div_op_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/taiga_types.sv
// Shared enums for the divider front/back-end sequencer.
// Op encoding matches the issue stage; state enum is the sequencer FSM.
// Helpers decode signedness and quotient/remainder selection from the op.
package taiga_types;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    DIV_SEQ_IDLE  = 2'd0,
    DIV_SEQ_RUN   = 2'd1,
    DIV_SEQ_WB    = 2'd2,
    DIV_SEQ_DRAIN = 2'd3
  } div_seq_state_t;

  // DIV and REM are the signed flavours (even encodings).
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // REM and REMU return the remainder (upper half of the encoding).
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_op_sequencer.sv
// Divider front/back end: operand magnitudes, core start/ack handshake, sign/zero fixup, last-operand cache.
// Latency: miss = core latency + 1 cycle after core_complete; cache hit = result one cycle after accept.
// Backpressure: single outstanding op; issue_ready only in IDLE, result held until wb_ack, stale complete drained.
import taiga_types::*;

module div_op_sequencer #(
  parameter int C_WIDTH = 32,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [1:0]         issue_op,
  input  logic [C_WIDTH-1:0] issue_rs1,
  input  logic [C_WIDTH-1:0] issue_rs2,
  input  logic [ID_W-1:0]    issue_id,
  output logic               core_start,
  output logic               core_ack,
  output logic [C_WIDTH-1:0] core_A,
  output logic [C_WIDTH-1:0] core_B,
  input  logic [C_WIDTH-1:0] core_Q,
  input  logic [C_WIDTH-1:0] core_R,
  input  logic               core_complete,
  input  logic               core_B_is_zero,
  output logic               wb_valid,
  input  logic               wb_ack,
  output logic [C_WIDTH-1:0] wb_rd,
  output logic [ID_W-1:0]    wb_id
);

  div_seq_state_t state_q, state_d;

  logic [1:0]         op_q;
  logic [ID_W-1:0]    id_q;
  logic               neg1_q, neg2_q;
  logic [C_WIDTH-1:0] core_a_q, core_b_q;
  logic               core_start_q, core_ack_q;
  logic [C_WIDTH-1:0] quo_q, rem_q;

  // Last-operand cache: key is (rs1, rs2, signedness), payload is the fixed-up pair.
  logic [C_WIDTH-1:0] c_rs1_q, c_rs2_q, c_quo_q, c_rem_q;
  logic               c_signed_q, cache_valid_q;

  logic               accept, cache_hit, capture;
  logic               iss_signed, iss_neg1, iss_neg2;
  logic [C_WIDTH-1:0] q_fix, r_fix;

  // Issue-side decode and cache lookup; the reset cycle must not show ready.
  always_comb begin
    issue_ready = (state_q == DIV_SEQ_IDLE) && !rst;
    accept      = issue_valid && issue_ready;
    iss_signed  = op_is_signed(issue_op);
    iss_neg1    = iss_signed && issue_rs1[C_WIDTH-1];
    iss_neg2    = iss_signed && issue_rs2[C_WIDTH-1];
    cache_hit   = cache_valid_q && (issue_rs1 == c_rs1_q) && (issue_rs2 == c_rs2_q)
                  && (iss_signed == c_signed_q);
  end

  // Sign and divide-by-zero fixup of the core result; the dividend magnitude is still held on core_A.
  always_comb begin
    q_fix = (neg1_q ^ neg2_q) ? -core_Q : core_Q;
    r_fix = neg1_q ? -core_R : core_R;
    if (core_B_is_zero) begin
      q_fix = '1;
      r_fix = neg1_q ? -core_a_q : core_a_q;
    end
  end

  // Next-state logic; capture fires on the first complete seen while running.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      DIV_SEQ_IDLE: begin
        if (accept) state_d = cache_hit ? DIV_SEQ_WB : DIV_SEQ_RUN;
      end
      DIV_SEQ_RUN: begin
        if (core_complete) begin
          capture = 1'b1;
          state_d = DIV_SEQ_WB;
        end
      end
      DIV_SEQ_WB: begin
        if (wb_ack) state_d = core_complete ? DIV_SEQ_DRAIN : DIV_SEQ_IDLE;
      end
      DIV_SEQ_DRAIN: begin
        if (!core_complete) state_d = DIV_SEQ_IDLE;
      end
      default: state_d = DIV_SEQ_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_SEQ_IDLE;
    else     state_q <= state_d;
  end

  // Operand, handshake, result and cache registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q          <= 2'd0;
      id_q          <= '0;
      neg1_q        <= 1'b0;
      neg2_q        <= 1'b0;
      core_a_q      <= '0;
      core_b_q      <= '0;
      core_start_q  <= 1'b0;
      core_ack_q    <= 1'b0;
      quo_q         <= '0;
      rem_q         <= '0;
      c_rs1_q       <= '0;
      c_rs2_q       <= '0;
      c_quo_q       <= '0;
      c_rem_q       <= '0;
      c_signed_q    <= 1'b0;
      cache_valid_q <= 1'b0;
    end else begin
      core_start_q <= accept && !cache_hit;
      core_ack_q   <= capture;
      if (accept) begin
        op_q <= issue_op;
        id_q <= issue_id;
        if (cache_hit) begin
          quo_q <= c_quo_q;
          rem_q <= c_rem_q;
        end else begin
          // A core run always replaces the cache; the key is valid only once the result lands.
          neg1_q        <= iss_neg1;
          neg2_q        <= iss_neg2;
          core_a_q      <= iss_neg1 ? -issue_rs1 : issue_rs1;
          core_b_q      <= iss_neg2 ? -issue_rs2 : issue_rs2;
          c_rs1_q       <= issue_rs1;
          c_rs2_q       <= issue_rs2;
          c_signed_q    <= iss_signed;
          cache_valid_q <= 1'b0;
        end
      end
      if (capture) begin
        quo_q         <= q_fix;
        rem_q         <= r_fix;
        c_quo_q       <= q_fix;
        c_rem_q       <= r_fix;
        cache_valid_q <= 1'b1;
      end
    end
  end

  assign core_start = core_start_q;
  assign core_ack   = core_ack_q;
  assign core_A     = core_a_q;
  assign core_B     = core_b_q;
  assign wb_valid   = (state_q == DIV_SEQ_WB);
  assign wb_rd      = op_is_rem(op_q) ? rem_q : quo_q;
  assign wb_id      = id_q;

endmodule
